// File: rtl/ndma_sub_pkg.sv
// Shared types and helpers for the OBI subordinate memory.
// Response record, LFSR constants and address range check.
package ndma_sub_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic addr_in_range(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned words
  );
    logic [33:0] off;
    logic [33:0] lim;
    off = {2'b00, addr - base};
    lim = {words[31:0], 2'b00};
    return (addr >= base) && (off < lim);
  endfunction

endpackage

// File: rtl/ndma_sub_rsp_fifo.sv
// Response FIFO holding completed responses until the
// manager accepts them on the R channel.
module ndma_sub_rsp_fifo
  import ndma_sub_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  rsp_t data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output rsp_t data_o
);

  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);

  rsp_t          mem_q [Depth];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) wptr_d = nxt(wptr_q);
    if (pop_ok)  rptr_d = nxt(rptr_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/ndma_obi_sub_mem.sv
// OBI subordinate SRAM with fixed-latency in-order responses.
// Define NDMA_SUB_STALL_EN for LFSR-driven random grant stalls.
module ndma_obi_sub_mem
  import ndma_sub_pkg::*;
#(
  parameter int unsigned NumWords       = 1024,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [31:0]            addr_i,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [DataWidth-1:0]   wdata_i,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   err_o
);

  localparam int unsigned AW   = $clog2(NumWords);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned NStg = (Latency > 1) ? Latency - 1 : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  logic [DataWidth-1:0] mem_q [NumWords];
  logic [CntW-1:0]      out_q, out_d;
  logic                 stall;
  logic                 a_hs;
  logic                 r_hs;
  logic                 in_range;
  logic [31:0]          offset;
  logic [AW-1:0]        idx;
  rsp_t                 hs_rsp;
  logic                 push;
  rsp_t                 push_rsp;
  logic                 fifo_full;
  logic                 fifo_empty;
  rsp_t                 head;
  logic                 unused_bits;

`ifdef NDMA_SUB_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  assign stall  = (lfsr_q[1:0] == 2'b00);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end
`else
  assign stall = 1'b0;
`endif

  assign gnt_o    = req_i && (out_q < MaxCnt) && !stall;
  assign a_hs     = req_i && gnt_o;
  assign r_hs     = rvalid_o && rready_i;
  assign in_range = addr_in_range(addr_i, BaseAddr, NumWords);
  assign offset   = addr_i - BaseAddr;
  assign idx      = offset[AW+1:2];

  assign unused_bits = ^{offset, fifo_full};

  always_comb begin
    hs_rsp.rdata = '0;
    hs_rsp.err   = !in_range;
    if (a_hs && !we_i && in_range) hs_rsp.rdata = mem_q[idx];
  end

  always_ff @(posedge clk_i) begin
    if (a_hs && we_i && in_range) begin
      for (int b = 0; b < DataWidth / 8; b++) begin
        if (be_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    out_d = out_q;
    unique case ({a_hs, r_hs})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) out_q <= '0;
    else         out_q <= out_d;
  end

  if (Latency > 1) begin : g_dly
    logic [NStg-1:0] vld_q, vld_d;
    rsp_t            rsp_q [NStg];
    rsp_t            rsp_d [NStg];

    always_comb begin
      vld_d[0] = a_hs;
      rsp_d[0] = hs_rsp;
      for (int unsigned i = 1; i < NStg; i++) begin
        vld_d[i] = vld_q[i-1];
        rsp_d[i] = rsp_q[i-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
        for (int unsigned i = 0; i < NStg; i++) rsp_q[i] <= '0;
      end else begin
        vld_q <= vld_d;
        for (int unsigned i = 0; i < NStg; i++) rsp_q[i] <= rsp_d[i];
      end
    end

    assign push     = vld_q[NStg-1];
    assign push_rsp = rsp_q[NStg-1];
  end else begin : g_nodly
    assign push     = a_hs;
    assign push_rsp = hs_rsp;
  end

  ndma_sub_rsp_fifo #(
    .Depth (MaxOutstanding)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_rsp),
    .pop_i   (r_hs),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_o  (head)
  );

  assign rvalid_o = !fifo_empty;
  assign rdata_o  = rvalid_o ? head.rdata : '0;
  assign err_o    = rvalid_o && head.err;

endmodule

// File: tb/tb_ndma_obi_sub_mem.sv
// Directed bench for ndma_obi_sub_mem: vector table on a
// Latency=1 instance plus sequences on a Latency=3 instance.
module tb_ndma_obi_sub_mem;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req1, gnt1, we1, rv1, rr1, err1;
  logic [31:0] addr1, wd1, rd1;
  logic [3:0]  be1;

  logic        req3, gnt3, we3, rv3, rr3, err3;
  logic [31:0] addr3, wd3, rd3;
  logic [3:0]  be3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ndma_obi_sub_mem u_dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req1),
    .gnt_o    (gnt1),
    .addr_i   (addr1),
    .we_i     (we1),
    .be_i     (be1),
    .wdata_i  (wd1),
    .rvalid_o (rv1),
    .rready_i (rr1),
    .rdata_o  (rd1),
    .err_o    (err1)
  );

  ndma_obi_sub_mem #(
    .Latency        (3),
    .MaxOutstanding (4)
  ) u_dut3 (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req3),
    .gnt_o    (gnt3),
    .addr_i   (addr3),
    .we_i     (we3),
    .be_i     (be3),
    .wdata_i  (wd3),
    .rvalid_o (rv3),
    .rready_i (rr3),
    .rdata_o  (rd3),
    .err_o    (err3)
  );

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rready;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic req, input logic we, input logic [31:0] addr,
    input logic [3:0] be, input logic [31:0] wdata,
    input logic gnt, input logic rvalid,
    input logic [31:0] rdata, input logic err
  );
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.be = be;
    v.wdata = wdata; v.rready = 1'b1; v.gnt = gnt;
    v.rvalid = rvalid; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic d1(input logic req, input logic we,
                    input logic [31:0] addr, input logic [3:0] be,
                    input logic [31:0] wd, input logic rr);
    req1 = req; we1 = we; addr1 = addr; be1 = be; wd1 = wd; rr1 = rr;
  endtask

  task automatic d3(input logic req, input logic we,
                    input logic [31:0] addr, input logic [31:0] wd);
    req3 = req; we3 = we; addr3 = addr; be3 = 4'hF; wd3 = wd;
    rr3 = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] wv [4];
    int n;
    logic exp_v;

    wv[0] = 32'h0BAD_F00D; wv[1] = 32'hCAFE_0001;
    wv[2] = 32'h1234_5678; wv[3] = 32'h8765_4321;

    // idle, writes, reads, byte enables, range errors, be=0
    vecs.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,         0, 0, 32'h0,         0));
    vecs.push_back(mk(1, 1, 32'h10,   4'hF, 32'hDEADBEEF,  1, 0, 32'h0,         0));
    vecs.push_back(mk(1, 0, 32'h10,   4'h0, 32'h0,         1, 1, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,         0, 1, 32'hDEADBEEF,  0));
    vecs.push_back(mk(1, 1, 32'h20,   4'hF, 32'h11223344,  1, 0, 32'h0,         0));
    vecs.push_back(mk(1, 1, 32'h20,   4'h1, 32'h000000AA,  1, 1, 32'h0,         0));
    vecs.push_back(mk(1, 0, 32'h20,   4'hF, 32'h0,         1, 1, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,         0, 1, 32'h112233AA,  0));
    vecs.push_back(mk(1, 0, 32'h1000, 4'hF, 32'h0,         1, 0, 32'h0,         0));
    vecs.push_back(mk(1, 0, 32'h10,   4'hF, 32'h0,         1, 1, 32'h0,         1));
    vecs.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,         0, 1, 32'hDEADBEEF,  0));
    vecs.push_back(mk(1, 1, 32'h1010, 4'hF, 32'hFFFFFFFF,  1, 0, 32'h0,         0));
    vecs.push_back(mk(1, 0, 32'h10,   4'hF, 32'h0,         1, 1, 32'h0,         1));
    vecs.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,         0, 1, 32'hDEADBEEF,  0));
    vecs.push_back(mk(1, 1, 32'h10,   4'h0, 32'h0,         1, 0, 32'h0,         0));
    vecs.push_back(mk(1, 0, 32'h13,   4'h0, 32'h0,         1, 1, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,         0, 1, 32'hDEADBEEF,  0));
    vecs.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,         0, 0, 32'h0,         0));

    rst_n = 1'b0;
    d1(0, 0, 0, 0, 0, 1);
    d3(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", gnt1, 0);
    chk("rst_rvalid", rv1, 0);
    chk("rst_rdata", rd1, 0);
    chk("rst_err", err1, 0);
    chk("rst_rvalid3", rv3, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      d1(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].be,
         vecs[i].wdata, vecs[i].rready);
      #1;
      chk($sformatf("v%0d_gnt", i), gnt1, vecs[i].gnt);
      chk($sformatf("v%0d_rvalid", i), rv1, vecs[i].rvalid);
      if (vecs[i].rvalid) begin
        chk($sformatf("v%0d_rdata", i), rd1, vecs[i].rdata);
        chk($sformatf("v%0d_err", i), err1, vecs[i].err);
      end
    end

    // backpressure: third request waits for the first R handshake
    @(posedge clk); #1; d1(1, 0, 32'h10, 4'hF, 0, 0); #1;
    chk("bp_gnt0", gnt1, 1);
    @(posedge clk); #1; d1(1, 0, 32'h20, 4'hF, 0, 0); #1;
    chk("bp_gnt1", gnt1, 1);
    chk("bp_rd1", rd1, 32'hDEADBEEF);
    @(posedge clk); #1; d1(1, 0, 32'h10, 4'hF, 0, 0); #1;
    chk("bp_gnt2", gnt1, 0);
    chk("bp_rv2", rv1, 1);
    chk("bp_rd2", rd1, 32'hDEADBEEF);
    @(posedge clk); #1; #1;
    chk("bp_gnt3", gnt1, 0);
    chk("bp_hold", rd1, 32'hDEADBEEF);
    @(posedge clk); #1; rr1 = 1'b1; #1;
    chk("bp_gnt4", gnt1, 0);
    chk("bp_rd4", rd1, 32'hDEADBEEF);
    @(posedge clk); #1; #1;
    chk("bp_gnt5", gnt1, 1);
    chk("bp_rd5", rd1, 32'h112233AA);
    @(posedge clk); #1; d1(0, 0, 0, 0, 0, 1); #1;
    chk("bp_rv6", rv1, 1);
    chk("bp_rd6", rd1, 32'hDEADBEEF);
    @(posedge clk); #1; #1;
    chk("bp_rv7", rv1, 0);

    // Latency=3 pipeline: fill four words then stream reads
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      d3(1, 1, 32'(4 * i), wv[i]); #1;
      chk($sformatf("l3_wgnt%0d", i), gnt3, 1);
    end
    @(posedge clk); #1; d3(0, 0, 0, 0); #1;
    n = 0;
    while (rv3 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    chk("l3_drain", 32'(n < 20), 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i < 4) d3(1, 0, 32'(4 * i), 0);
      else       d3(0, 0, 0, 0);
      #1;
      if (i < 4) chk($sformatf("l3_rgnt%0d", i), gnt3, 1);
      exp_v = (i >= 3) && (i < 7);
      chk($sformatf("l3_rv%0d", i), rv3, 32'(exp_v));
      if (exp_v) chk($sformatf("l3_rd%0d", i), rd3, wv[i-3]);
    end

    // reset with two responses pending
    @(posedge clk); #1; d1(1, 0, 32'h10, 4'hF, 0, 0); #1;
    chk("rs_gnt0", gnt1, 1);
    @(posedge clk); #1; d1(1, 0, 32'h20, 4'hF, 0, 0); #1;
    chk("rs_gnt1", gnt1, 1);
    @(posedge clk); #1; d1(0, 0, 0, 0, 0, 0); #1;
    chk("rs_pend", rv1, 1);
    #1; rst_n = 1'b0; #1;
    chk("rs_rv_now", rv1, 0);
    chk("rs_rd_now", rd1, 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      chk($sformatf("rs_stale%0d", i), rv1, 0);
    end
    @(posedge clk); #1; d1(1, 0, 32'h20, 4'hF, 0, 0); #1;
    chk("rs_gntA", gnt1, 1);
    @(posedge clk); #1; d1(1, 0, 32'h10, 4'hF, 0, 0); #1;
    chk("rs_gntB", gnt1, 1);
    chk("rs_rdA", rd1, 32'h112233AA);
    @(posedge clk); #1; #1;
    chk("rs_gntC", gnt1, 0);
    @(posedge clk); #1; d1(0, 0, 0, 0, 0, 1); #1;
    chk("rs_rdA2", rd1, 32'h112233AA);
    @(posedge clk); #1; #1;
    chk("rs_rdB", rd1, 32'hDEADBEEF);
    @(posedge clk); #1; #1;
    chk("rs_empty", rv1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ndma_obi_sub_mem.md
Name: ndma_obi_sub_mem

Overview:
- OBI subordinate (responder) memory: the far end of the DMA's read/write manager ports.
- Accepts OBI A-channel requests, performs word-addressed SRAM access with byte enables, returns R-channel responses in order after a fixed latency.
- Supports multiple outstanding transactions and R-channel backpressure.
- Used as the DMA's source/destination memory in the subsystem and in test benches.

Parameters:
- NumWords, 1024, storage depth in 32-bit words (power of two, >=2).
- DataWidth, 32, data bus width; fixed at 32, be_i is DataWidth/8.
- Latency, 1, cycles from A-handshake to earliest rvalid_o (1..8).
- MaxOutstanding, 2, max accepted-but-unretired transactions (1..8); also sets response FIFO depth.
- BaseAddr, 32'h0000_0000, byte address of word 0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  1  A-channel request
- gnt_o  out  1  A-channel grant
- addr_i  in  32  byte address
- we_i  in  1  1=write, 0=read
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  R-channel response valid
- rready_i  in  1  R-channel ready from manager
- rdata_o  out  32  read data (0 for writes)
- err_o  out  1  response error flag

Behaviour:
- Reset: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0. Outstanding counter, delay line and FIFO are cleared. Memory contents are not reset.
- A-handshake = req_i && gnt_o.
- gnt_o = req_i && (outstanding_q < MaxOutstanding). Combinational; no retirement look-ahead.
- outstanding_q: +1 on A-handshake, -1 on R-handshake (rvalid_o && rready_i), unchanged when both occur. Width $clog2(MaxOutstanding+1).
- Address decode:
  - offset = addr_i - BaseAddr; word index = offset[.. :2].
  - Out of range when offset >= NumWords*4, or addr_i < BaseAddr: no memory access, response err=1, rdata=0.
  - addr_i[1:0] is ignored.
- Access timing: memory access happens in the A-handshake cycle.
  - Write: each byte i is updated where be_i[i]=1; be_i=0 is a legal no-op write.
  - Read: returns the full word; be_i is ignored.
  - A read granted the cycle after a write to the same word returns the written data.
- Delay line: Latency-1 register stages carrying {valid, rdata, err}. The handshake cycle result enters stage 0. With Latency=1 the result goes directly to the FIFO at the next edge.
- Response FIFO:
  - Depth MaxOutstanding; the counter guarantees no overflow.
  - rvalid_o = !empty. rdata_o/err_o = FIFO head, held stable while rvalid_o && !rready_i.
  - Pop on R-handshake. Push and pop in the same cycle are both honoured.
- Ordering: responses are strictly in grant order.
- Min latency: a request granted in cycle N yields rvalid_o in cycle N+Latency if the FIFO is empty.
- Throughput: 1 transaction/cycle when rready_i=1 and MaxOutstanding >= Latency+1.
- Reset mid-transaction drops all in-flight responses; no response is generated after reset release.
- Manager must hold req_i/addr/we/be/wdata until grant (OBI rule). The block does not check this.

Optional Feature:
- Macro NDMA_SUB_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1; reset to seed) advances every cycle.
  - gnt_o is additionally gated low when lfsr_q[1:0]==2'b00, giving ~25% random grant stalls for DMA stress.
  - Stall decisions are deterministic from reset.
- Undefined: no LFSR logic; gnt_o follows the base rule only.

Decomposition:
- Package ndma_sub_pkg holds:
  - rsp_t struct {logic [31:0] rdata; logic err;}
  - LFSR_SEED and LFSR tap constant
  - function addr_in_range(addr, base, words)
- Sub-module ndma_sub_rsp_fifo: rsp_t FIFO, parameter Depth, ports push/pop/full/empty/data.
- Delay line and memory array stay inline.

Test Plan:
- Write addr 0x10, wdata 0xDEADBEEF, be 4'hF, then read 0x10, Latency=1, rready=1 -> write response rdata=0 err=0 in cycle N+1; read response 0xDEADBEEF one cycle after its grant.
- Write 0x0000_00AA with be 4'b0001 over 0x1122_3344 at 0x20 -> subsequent read returns 0x1122_33AA.
- Read addr NumWords*4 (0x1000) -> gnt=1, response err=1, rdata=0; memory unchanged.
- MaxOutstanding=2, rready=0, 3 back-to-back reads -> first two granted, third gnt=0 until first R-handshake; responses in grant order.
- Latency=3, rready=1, continuous reads of 0x0,0x4,0x8,0xC -> rvalid first at grant+3, then every cycle with correct data when MaxOutstanding>=4.
- Assert rst_ni low with 2 responses pending -> rvalid_o=0 immediately; after release no stale responses; outstanding count 0 (gnt_o=req_i).
